// File: rtl/tl_ul_sram_responder.sv
`default_nettype none
// tl_ul_sram_responder (rev 1.0): TL-UL manager serving Get/Put from a word-addressed scratch RAM
// through a 2-entry in-order response FIFO. Define TL_UL_SRAM_RESPONDER_ERRCNT_EN to add err_count.
module tl_ul_sram_responder #(
  parameter int          DEPTH = 64,
  parameter logic [29:0] BASE  = 30'h0,
  parameter int          SRC_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_param,
  input  logic [2:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [29:0]      a_address,
  input  logic [3:0]       a_mask,
  input  logic [31:0]      a_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [1:0]       d_param,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic             d_denied,
  output logic [31:0]      d_data,
  output logic             d_corrupt
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [30:0] LIMIT = {1'b0, BASE} + 31'(4 * DEPTH);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic [31:0]      data;
  } entry_t;

  logic [31:0] mem [DEPTH];
  entry_t      fifo_q [2];
  entry_t      new_entry;
  entry_t      head;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;

  logic [29:0]   offset;
  logic [AW-1:0] index;
  logic [3:0]    full_mask;
  logic          misaligned;
  logic          op_ok;
  logic          in_range;
  logic          denied;
  logic          is_get;
  logic          push;
  logic          pop;
  logic          unused_offset_bits;

  assign offset             = a_address - BASE;
  assign index              = offset[AW+1:2];
  assign unused_offset_bits = ^{offset[29:AW+2], offset[1:0]};

  always_comb begin
    full_mask  = 4'hF;
    misaligned = 1'b0;
    case (a_size)
      3'd0: full_mask = 4'b0001 << a_address[1:0];
      3'd1: begin
        full_mask  = a_address[1] ? 4'b1100 : 4'b0011;
        misaligned = a_address[0];
      end
      default: misaligned = |a_address[1:0];
    endcase
  end

  assign op_ok    = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
  assign in_range = ({1'b0, a_address} >= {1'b0, BASE}) && ({1'b0, a_address} < LIMIT);
  assign denied   = !op_ok || (a_param != 3'd0) || (a_size > 3'd2) || misaligned || !in_range
                 || ((a_opcode == 3'd0) && (a_mask != full_mask));
  assign is_get   = (a_opcode == 3'd4);

  assign d_valid = (count != 2'd0);
  // A full FIFO can still take a request when its head leaves on the same edge.
  assign a_ready = reset && (!count[1] || d_ready);
  assign push    = a_valid && a_ready;
  assign pop     = d_valid && d_ready;

  always_comb begin
    new_entry.opcode = is_get ? 3'd1 : 3'd0;
    new_entry.size   = a_size;
    new_entry.source = a_source;
    new_entry.denied = denied;
    new_entry.data   = (is_get && !denied) ? mem[index] : 32'h0;
  end

  // Read data is captured from the pre-edge RAM contents, so a same-edge write cannot leak in.
  always_ff @(posedge clock) begin
    if (push && !denied && !is_get) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) mem[index][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= new_entry;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head      = fifo_q[rd_ptr];
  assign d_opcode  = head.opcode;
  assign d_param   = 2'd0;
  assign d_size    = head.size;
  assign d_source  = head.source;
  assign d_denied  = head.denied;
  assign d_data    = head.data;
  assign d_corrupt = head.denied && (head.opcode == 3'd1);

`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_cnt <= 16'd0;
    end else if (push && denied && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign err_count = err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_sram_responder.sv
`default_nettype none
// tb_tl_ul_sram_responder: directed and randomized requests checked against a byte-level
// TL-UL RAM model; a negedge monitor scores every D beat and the ready/valid rules.
module tb_tl_ul_sram_responder;
  localparam int          DEPTH = 64;
  localparam logic [29:0] BASE  = 30'h400;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [29:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  tl_ul_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .SRC_W(4)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .d_corrupt(d_corrupt)
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  int          err_model = 0;
  int          cycle = 0;
  bit          rand_dr = 0;
  bit          hold = 0;
  logic [45:0] held;
  logic [45:0] exp_q[$];
  logic [7:0]  mbytes [4*DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected D beat {opcode,param,size,source,denied,data,corrupt}; applies legal Puts to the model.
  function automatic logic [45:0] model_req(input logic [2:0] op, input logic [2:0] prm,
      input logic [2:0] sz, input logic [3:0] src, input logic [29:0] addr,
      input logic [3:0] mask, input logic [31:0] data);
    longint a   = longint'(addr);
    longint lo  = longint'(BASE);
    longint hi  = longint'(BASE) + 4 * DEPTH;
    bit     den = 0;
    int     nb;
    int     wb;
    logic [31:0] rd = 32'h0;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) den = 1;
    if (prm != 3'd0) den = 1;
    if (sz > 3'd2) den = 1;
    else begin
      nb = 1 << sz;
      if (a % nb != 0) den = 1;
      else if (op == 3'd0 && mask != 4'(((1 << nb) - 1) << (a % 4))) den = 1;
    end
    if (a < lo || a >= hi) den = 1;
    if (!den) begin
      wb = int'((a - lo) / 4) * 4;
      for (int i = 0; i < 4; i++) begin
        if (op == 3'd4) rd[8*i +: 8] = mbytes[wb + i];
        else if (mask[i]) mbytes[wb + i] = data[8*i +: 8];
      end
    end
    if (den && err_model < 65535) err_model++;
    return {(op == 3'd4) ? 3'd1 : 3'd0, 2'd0, sz, src, den, rd, den && (op == 3'd4)};
  endfunction

  always @(posedge clock) cycle++;

  always @(posedge clock) begin
    #1;
    if (rand_dr) d_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    logic [45:0] act;
    logic [45:0] e;
    act = {d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt};
    if (hold) begin
      chk("stable_valid", 64'(d_valid), 64'd1);
      chk("stable_fields", 64'(act), 64'(held));
    end
    chk("d_valid", 64'(d_valid), 64'(exp_q.size() != 0));
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    chk("err_count", 64'(err_count), 64'(err_model));
`endif
    if (!reset) begin
      chk("a_ready_in_reset", 64'(a_ready), 64'd0);
      exp_q.delete();
      err_model = 0;
      hold = 0;
    end else begin
      chk("a_ready", 64'(a_ready), 64'((exp_q.size() < 2) || d_ready));
      if (d_valid && d_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(act), 64'h0);
        else begin
          e = exp_q.pop_front();
          chk("d_beat", 64'(act), 64'(e));
        end
      end
      if (a_valid && a_ready)
        exp_q.push_back(model_req(a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data));
      hold = d_valid && !d_ready;
      held = act;
    end
  end

  task automatic set_req(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
      input logic [3:0] src, input logic [29:0] addr, input logic [3:0] mask,
      input logic [31:0] data);
    a_valid = 1'b1; a_opcode = op; a_param = prm; a_size = sz;
    a_source = src; a_address = addr; a_mask = mask; a_data = data;
  endtask

  // Returns just after the edge on which the pending request was accepted.
  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (a_ready) got = 1;
      @(posedge clock); #1;
    end
    chk("accept", 64'(got), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ops [8];
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [29:0] addr;
    logic [3:0]  mask;
    int          c0;
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    logic [15:0] e0;
`endif
    ops = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd4, 3'd2, 3'd5};
    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    set_req(3'd0, 3'd0, 3'd0, 4'd0, 30'd0, 4'd0, 32'd0);
    a_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_d_valid", 64'(d_valid), 64'd0);
    chk("reset_a_ready", 64'(a_ready), 64'd0);
    chk("reset_d_fields", 64'({d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt}), 64'd0);
    reset = 1'b1;
    d_ready = 1'b1;

    for (int w = 0; w < DEPTH; w++) begin
      set_req(3'd0, 3'd0, 3'd2, 4'(w), 30'(BASE + 4 * w), 4'hF, $urandom);
      wait_accept();
    end
    a_valid = 1'b0;
    drain();

    set_req(3'd0, 3'd0, 3'd2, 4'd3, 30'(BASE + 8), 4'hF, 32'hDEADBEEF);
    wait_accept(); a_valid = 1'b0;
    chk("put_ack", 64'({d_valid, d_opcode, d_source, d_denied}), 64'({1'b1, 3'd0, 4'd3, 1'b0}));
    set_req(3'd4, 3'd0, 3'd2, 4'd5, 30'(BASE + 8), 4'hF, 32'h0);
    wait_accept(); a_valid = 1'b0;
    chk("get_latency", 64'({d_valid, d_opcode, d_source}), 64'({1'b1, 3'd1, 4'd5}));
    chk("get_data", 64'(d_data), 64'h00000000DEADBEEF);

    set_req(3'd0, 3'd0, 3'd2, 4'd1, 30'(BASE + 16), 4'hF, 32'hAAAAAAAA);
    wait_accept();
    set_req(3'd1, 3'd0, 3'd2, 4'd2, 30'(BASE + 16), 4'b0101, 32'h11223344);
    wait_accept();
    set_req(3'd4, 3'd0, 3'd2, 4'd4, 30'(BASE + 16), 4'hF, 32'h0);
    wait_accept(); a_valid = 1'b0;
    chk("partial_data", 64'(d_data), 64'h00000000AA22AA44);

`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    e0 = err_count;
`endif
    set_req(3'd4, 3'd0, 3'd2, 4'd6, 30'(BASE + 4 * DEPTH), 4'hF, 32'h0);
    wait_accept(); a_valid = 1'b0;
    chk("oob_get", 64'({d_opcode, d_denied, d_corrupt, d_data}), 64'({3'd1, 1'b1, 1'b1, 32'h0}));
    set_req(3'd2, 3'd0, 3'd2, 4'd7, BASE, 4'hF, 32'h12345678);
    wait_accept(); a_valid = 1'b0;
    chk("bad_opcode", 64'({d_opcode, d_denied, d_corrupt}), 64'({3'd0, 1'b1, 1'b0}));
    set_req(3'd4, 3'd0, 3'd3, 4'd8, BASE, 4'hF, 32'h0);
    wait_accept(); a_valid = 1'b0;
    chk("bad_size", 64'({d_denied, d_size}), 64'({1'b1, 3'd3}));
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    chk("err_count_delta", 64'(err_count - e0), 64'd3);
`endif
    drain();

    d_ready = 1'b0;
    set_req(3'd4, 3'd0, 3'd2, 4'd0, 30'(BASE + 8), 4'hF, 32'h0);
    wait_accept();
    set_req(3'd4, 3'd0, 3'd2, 4'd1, 30'(BASE + 16), 4'hF, 32'h0);
    wait_accept();
    set_req(3'd4, 3'd0, 3'd2, 4'd2, 30'(BASE + 8), 4'hF, 32'h0);
    repeat (3) begin
      @(negedge clock);
      chk("bp_full", 64'({a_ready, d_valid, d_source}), 64'({1'b0, 1'b1, 4'd0}));
      @(posedge clock); #1;
    end
    d_ready = 1'b1;
    @(negedge clock);
    chk("bp_third_with_pop", 64'(a_ready), 64'd1);
    @(posedge clock); #1;
    a_valid = 1'b0;
    chk("bp_second_head", 64'(d_source), 64'd1);
    drain();

    c0 = cycle;
    for (int k = 0; k < 20; k++) begin
      set_req(3'd4, 3'd0, 3'd2, 4'(k), 30'(BASE + 4 * $urandom_range(0, DEPTH - 1)), 4'hF, 32'h0);
      wait_accept();
    end
    a_valid = 1'b0;
    chk("throughput_cycles", 64'(cycle - c0), 64'd20);
    drain();

    rand_dr = 1;
    for (int k = 0; k < 300; k++) begin
      op   = ops[$urandom_range(0, 7)];
      sz   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      addr = 30'(BASE - 8 + $urandom_range(0, 4 * DEPTH + 15));
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'd0;
      mask = 4'($urandom);
      if (op == 3'd0 && sz <= 3'd2 && $urandom_range(0, 3) != 0)
        mask = 4'(((1 << (1 << sz)) - 1) << (addr % 4));
      set_req(op, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0, sz,
              4'($urandom), addr, mask, $urandom);
      wait_accept();
      if ($urandom_range(0, 4) == 0) begin
        a_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
    a_valid = 1'b0;
    rand_dr = 0;
    #1 d_ready = 1'b1;
    drain();

    d_ready = 1'b0;
    set_req(3'd0, 3'd0, 3'd2, 4'd1, 30'(BASE + 32), 4'hF, 32'h01010101);
    wait_accept();
    set_req(3'd0, 3'd0, 3'd2, 4'd2, 30'(BASE + 36), 4'hF, 32'h02020202);
    wait_accept(); a_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("midreset_d_valid", 64'(d_valid), 64'd0);
    chk("midreset_fields", 64'({d_opcode, d_size, d_source, d_denied, d_data}), 64'd0);
    d_ready = 1'b1;
    set_req(3'd0, 3'd0, 3'd2, 4'd9, 30'(BASE + 40), 4'hF, 32'h09090909);
    wait_accept(); a_valid = 1'b0;
    chk("post_reset_put", 64'({d_valid, d_source, d_denied}), 64'({1'b1, 4'd9, 1'b0}));
    repeat (5) @(posedge clock);
    #1;
    chk("no_stale_beat", 64'(d_valid), 64'd0);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (manager side) terminating the A channel and generating D-channel responses; the counterpart to the initiator that our TL monitors observe.
- Backs a small word-addressed scratch RAM used as a bus target in core-complex testbenches.
- Serves Get, PutFullData and PutPartialData in order through a 2-entry response FIFO.
- Answers illegal requests with denied AccessAck/AccessAckData.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 2..1024.
- BASE, 30'h0, byte base address of the RAM window.
- SRC_W, 4, source ID width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  reset is synchronous and active-low: 0 resets on a clock edge.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted when a_valid&a_ready.
- a_opcode  in  3  0 = PutFull, 1 = PutPartial, 4 = Get; others illegal.
- a_param  in  3  must be 0.
- a_size  in  3  log2 bytes; legal 0..2.
- a_source  in  SRC_W  request ID.
- a_address  in  30  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted when d_valid&d_ready.
- d_opcode  out  3  0 = AccessAck, 1 = AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echoes a_size.
- d_source  out  SRC_W  echoes a_source.
- d_denied  out  1  request rejected.
- d_data  out  32  read data; 0 when d_denied or not a Get.
- d_corrupt  out  1  equals d_denied on AccessAckData, else 0.

Behaviour:
- Reset (reset==0 at an edge): FIFO count←0, rd/wr pointers←0, d_valid=0, a_ready=0 during reset, all d_* fields←0. RAM contents are not reset.
- a_ready=1 when count<2, or when count==2 and d_ready&d_valid (same-cycle pop frees a slot).
- Latency: a request accepted at edge N is visible on d_* after that edge. With an empty FIFO, d_valid is high in cycle N+1. There is no combinational A→D path.
- Legality: the request is denied if any of the following holds:
  - opcode ∉ {0,1,4};
  - a_param≠0;
  - a_size>2;
  - the address is misaligned to a_size;
  - the address is outside [BASE, BASE+4*DEPTH);
  - on PutFull, a_mask does not equal the full mask for size and offset.
- Denied requests do not touch the RAM.
- Put (legal): on the accept edge, each byte lane i with a_mask[i]=1 is written at index (a_address-BASE)>>2. Response: AccessAck, denied=0.
- Get (legal): read at the accept edge sees the RAM state before any write in that same edge. Full word captured into the FIFO entry; d_data is the word, lanes not masked are still returned. Response: AccessAckData.
- Ordering: strict in-order. A Get following a Put to the same word returns the written data.
- FIFO: 2 entries of {opcode, size, source, denied, data}.
  - Push on A fire, pop on D fire.
  - Simultaneous push and pop: count unchanged, pointers both advance (1-bit wrap).
- d_* fields are stable while d_valid&!d_ready. d_valid never drops without a handshake.
- Reset mid-transaction: pending responses are discarded; no D beat for them is ever issued.

Optional Feature:
- Macro: TL_UL_SRAM_RESPONDER_ERRCNT_EN.
- When defined:
  - adds output err_count [15:0], incremented on each accepted denied request;
  - saturates at 16'hFFFF;
  - resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Put then Get: PutFull addr BASE+8, mask F, data 32'hDEADBEEF, source 3 → AccessAck src 3 denied 0. Then Get size 2 at the same address → AccessAckData data DEADBEEF, d_valid one cycle after accept.
- Partial write: PutPartial mask 4'b0101, data 32'h11223344 onto word 32'hAAAAAAAA → later Get returns 32'hAA22AA44.
- Errors: Get at BASE+4*DEPTH → d_denied=1, d_corrupt=1, d_data=0. Opcode 2 → AccessAck denied. Get size 3 → denied. With the macro defined, err_count=3.
- Backpressure: hold d_ready=0 and issue 3 back-to-back Gets → a_ready deasserts after 2 accepts and d_* stays stable. Release d_ready → responses arrive in source order 0,1,2, and the third is accepted on the same cycle as the first pop.
- Throughput: d_ready=1 and continuous Gets → one accept and one response per cycle, FIFO count toggles ≤1.
- Reset mid-flight: 2 responses queued, then reset low for 1 cycle → d_valid=0 and no stale beat. The next Put after reset gets the only response.
